// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped countdown timers:
// register offsets, CTRL bit positions, mode codes and FSM states.
package timer_counter_pkg;

    localparam logic [31:0] TIMER0_BASE = 32'h0000_7f00;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_7f10;

    localparam logic [1:0] REG_CTRL   = 2'b00;
    localparam logic [1:0] REG_PRESET = 2'b01;
    localparam logic [1:0] REG_COUNT  = 2'b10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE_L = 1;
    localparam int CTRL_MODE_H = 2;
    localparam int CTRL_IM     = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_e;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer slave on the data-memory path: CTRL/PRESET/COUNT
// registers, zero-latency read port and a level IRQ to CP0.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER0_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    logic [3:0]  ctrl_q,   ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q,  count_d;
    logic        irq_q,    irq_d;
    state_e      state_q,  state_d;

    logic       hit;
    logic [1:0] sel;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       en_next;
    logic       irq_set;

    assign hit       = (Addr[31:4] == BASE_ADDR[31:4]);
    assign sel       = Addr[3:2];
    assign wr_ctrl   = WE && hit && (sel == REG_CTRL);
    assign wr_preset = WE && hit && (sel == REG_PRESET);

    // IDLE looks through a same-cycle CTRL store so an enable starts loading at once
    assign en_next = wr_ctrl ? WD[CTRL_EN] : ctrl_q[CTRL_EN];

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
        state_d  = state_q;
        irq_set  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en_next) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    irq_set = 1'b1;
                    irq_d   = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q[CTRL_MODE_H:CTRL_MODE_L] == MODE_AUTO) begin
                    irq_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
                state_d = ST_IDLE;
            end
        endcase

        // Stores override the FSM, except that a fresh interrupt is never acked away
        if (wr_ctrl) begin
            ctrl_d = WD[3:0];
            if (!irq_set) irq_d = 1'b0;
        end
        if (wr_preset) preset_d = WD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        RD = 32'd0;
        if (hit) begin
            unique case (sel)
                REG_CTRL:   RD = {28'd0, ctrl_q};
                REG_PRESET: RD = preset_q;
                REG_COUNT:  RD = count_q;
                default:    RD = 32'd0;
            endcase
        end
    end

    assign IRQ = irq_q & ctrl_q[CTRL_IM];

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped countdown timer that sits directly downstream of the data-memory stage.
- The DM stage decodes the timer window (0x7f00–0x7f0b for timer 0, 0x7f10–0x7f1b for timer 1) and raises PrWrite for word stores there. This block holds CTRL/PRESET/COUNT, returns read data to the load path and drives a level interrupt request to CP0.
- Two instances are built, one per BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h0000_7f00, word-aligned base of this timer's 16-byte window (second instance uses 32'h0000_7f10).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- Addr  input  32  byte address from the M stage (ALU result)
- WE  input  1  write strobe, driven by the DM PrWrite output (already gated by exception/interrupt)
- WD  input  32  store data
- RD  output  32  combinational read data for the addressed register
- IRQ  output  1  interrupt request to CP0, level

Behaviour:
- Hit: Addr[31:4] == BASE_ADDR[31:4]. Register select is Addr[3:2]:
  - 00 CTRL
  - 01 PRESET
  - 10 COUNT (read-only)
  - 11 unmapped
- CTRL layout:
  - [0] EN
  - [2:1] MODE (00 one-shot, 01 auto-reload; 10/11 behave as 00)
  - [3] IM (interrupt mask, 1 = enabled)
  - [31:4] read as 0
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0. RD follows from the reset register values.
- Read: RD = {28'b0,CTRL} / PRESET / COUNT by select; 0 for select 11 or no hit. Pure combinational, zero latency.
- Write (WE && hit), taking effect at the next rising edge:
  - CTRL: CTRL <= WD[3:0]; irq_flag <= 0 (acknowledge).
  - PRESET: PRESET <= WD.
  - COUNT or select 11: ignored.
- FSM (2-bit state):
  - IDLE: EN=1 → LOAD; else stay.
  - LOAD: COUNT <= PRESET → CNT.
  - CNT, EN=0: → IDLE; COUNT holds.
  - CNT, EN=1 and COUNT>1: COUNT <= COUNT-1, stay.
  - CNT, EN=1 and COUNT<=1 (covers PRESET=0): COUNT <= 0, irq_flag <= 1 → INT.
  - INT, MODE one-shot: CTRL[0] <= 0 → IDLE; irq_flag stays set until a CTRL write or reset.
  - INT, MODE auto-reload: irq_flag <= 0 → IDLE. Count restarts via LOAD if EN is still 1.
- IRQ = irq_flag & CTRL[3]. The flag is internal; changing IM alone never loses a pending flag except through the CTRL-write acknowledge.
- Timing: with PRESET=N≥1, enable written at edge t0:
  - COUNT=N after t1.
  - COUNT=0 and IRQ=1 after t(N+1).
  - Auto-reload period is N+3 cycles, with IRQ high for exactly 1 cycle.
- Simultaneous events:
  - CTRL write in the same cycle as INT clearing EN: the written value wins.
  - CTRL write in the same cycle irq_flag would be set: the set wins (interrupt not lost).
  - PRESET write during CNT does not affect the running count; it is used at the next LOAD.
- Reset mid-count: all state cleared asynchronously, IRQ drops immediately, no pending interrupt survives.
- COUNT never wraps below 0.

Decomposition:
- define.v gains:
  - register offset constants (CTRL/PRESET/COUNT)
  - CTRL bit indices
  - MODE codes
  - FSM state encodings (IDLE/LOAD/CNT/INT)
  - the two timer base addresses
- Single flat module; no sub-module needed.

Test Plan:
- Reset then read 0x7f00/04/08/0c → RD=0 for all, IRQ=0; write 0x7f08 with 5 → COUNT still reads 0.
- One-shot:
  - Stimulus: PRESET=3, then CTRL=4'b1001 at t0.
  - COUNT reads 3,2,1,0 after t1..t4; IRQ rises after t4.
  - CTRL reads 4'b1000 after t5; IRQ stays 1 until a CTRL write of 0, then 0 on the next edge.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=4'b1011.
  - IRQ is a 1-cycle pulse every 5 cycles; COUNT sequence 2,1,0,0,0 repeats.
- Mask: PRESET=1, CTRL=4'b0001 → COUNT hits 0, IRQ stays 0. Then writing CTRL=4'b1000 acknowledges, so IRQ stays 0.
- Disable mid-count: PRESET=10, enable, clear EN after 4 cycles → COUNT freezes at 7 and IRQ never asserts. Re-enable → COUNT reloads to 10.
- Async reset asserted mid-CNT between clock edges → COUNT/CTRL/IRQ read 0 before the next edge. Second instance (BASE 0x7f10) is unaffected by writes to 0x7f04.
